// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, branch codes,
// datapath mux encodings and the control FSM state set.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // REGIMM sub-op carried in the rt field
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_GEZ  = 3'b011,
    BR_LEZ  = 3'b100,
    BR_GTZ  = 3'b101
  } br_code_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    PCSEL_ALU    = 2'b00,
    PCSEL_ALUOUT = 2'b01,
    PCSEL_JUMP   = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } src_b_t;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_ALUWB, S_EXEC_I, S_IMMWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Memory request/ready handshake between the control FSM and the memory port.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Wait-state counter: cleared on state entry, counts cycles without mem_ready,
// flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [TO_W-1:0] r_cnt;

  // Count wait cycles; clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == TO_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: decodes the IR opcode and sequences
// ALU, register file and memory, with memory timeout and illegal-opcode traps.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt,
  input  logic        pc_src,
  mips_multicycle_ctrl_if.master mem,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  branch,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        bus_error,
  output logic        illegal_op
);
  state_t r_state, w_next;
  logic   r_bus_err, r_ill_op;
  logic   w_set_bus, w_set_ill;
  logic   w_mem_req, w_mem_we, w_i_or_d;
  logic   w_wait, w_expired;

  assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  // Clearing on every state change restarts the count on entry to each wait state
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state != w_next),
    .i_en      (w_wait && !mem.mem_ready),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_next;
  end

  // Sticky trap flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
      r_ill_op  <= 1'b0;
    end else begin
      if (w_set_bus) r_bus_err <= 1'b1;
      if (w_set_ill) r_ill_op  <= 1'b1;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_next     = r_state;
    w_set_bus  = 1'b0;
    w_set_ill  = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_i_or_d   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PCSEL_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    branch     = BR_NONE;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (r_state)
      S_BOOT: w_next = S_FETCH;
      S_FETCH: begin
        w_mem_req = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem.mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_RTYPE:                          w_next = S_EXEC_R;
          OP_LW, OP_SW:                      w_next = S_MEMADR;
          OP_ADDI:                           w_next = S_EXEC_I;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  w_next = S_BRANCH;
          OP_J:                              w_next = S_JUMP;
          OP_REGIMM: begin
            if (rt == RT_BGEZ) w_next = S_BRANCH;
            else begin
              w_next    = S_TRAP;
              w_set_ill = 1'b1;
            end
          end
          default: begin
            w_next    = S_TRAP;
            w_set_ill = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
        if (mem.mem_ready) w_next = S_MEMWB;
        else if (w_expired) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_i_or_d  = 1'b1;
        if (mem.mem_ready) w_next = S_FETCH;
        else if (w_expired) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        w_next  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_IMMWB;
      end
      S_IMMWB: begin
        reg_we = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_sel    = PCSEL_ALUOUT;
        pc_we     = pc_src;
        w_next    = S_FETCH;
        case (opcode)
          OP_BEQ:    branch = BR_EQ;
          OP_BNE:    branch = BR_NE;
          OP_BLEZ:   branch = BR_LEZ;
          OP_BGTZ:   branch = BR_GTZ;
          OP_REGIMM: branch = BR_GEZ;
          default:   branch = BR_NONE;
        endcase
      end
      S_JUMP: begin
        pc_sel = PCSEL_JUMP;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_BOOT;
    endcase
  end

  assign mem.mem_req = w_mem_req;
  assign mem.mem_we  = w_mem_we;
  assign mem.i_or_d  = w_i_or_d;
  assign bus_error   = r_bus_err;
  assign illegal_op  = r_ill_op;
endmodule
